// File: rtl/debug_frame_receiver.sv
// Fixed-length debug frame receiver: N payload bytes (MSB byte first) then 8'h0A,
// with resync on a bad terminator and an inter-byte timeout inside a frame.
module debug_frame_receiver #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [27:0] TIMEOUT_TICKS = 28'd2000000
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_valid,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic [15:0]           error_count,
    output logic [15:0]           frame_count,
    output logic [2:0]            state
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]       NL       = 8'h0A;

    typedef enum logic [2:0] {
        COLLECT   = 3'b001,
        EXPECT_NL = 3'b010,
        RESYNC    = 3'b100
    } state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      index_q;
    logic [27:0]           timer_q;
    logic [DATA_WIDTH-1:0] shift_q;

    logic        timer_run_c;
    logic [27:0] timer_next_c;
    logic        timeout_c;
    logic        bad_nl_c;

    assign state = state_q;

    // Timer only runs while a frame is partially received; a byte in the timeout cycle wins.
    assign timer_run_c  = ((state_q == COLLECT) && (index_q != '0)) || (state_q == EXPECT_NL);
    assign timer_next_c = timer_q + 28'd1;
    assign timeout_c    = !rx_byte_valid && timer_run_c && (timer_next_c == TIMEOUT_TICKS);
    assign bad_nl_c     = rx_byte_valid && (state_q == EXPECT_NL) && (rx_byte != NL);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            index_q     <= '0;
            timer_q     <= '0;
            shift_q     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (rx_byte_valid) begin
                timer_q <= '0;
                case (state_q)
                    COLLECT: begin
                        shift_q <= (shift_q << 8) | DATA_WIDTH'(rx_byte);
                        if (index_q == LAST_IDX) begin
                            index_q <= '0;
                            state_q <= EXPECT_NL;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                        end
                    end
                    EXPECT_NL: begin
                        if (rx_byte == NL) begin
                            frame_data  <= shift_q;
                            frame_valid <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            state_q     <= COLLECT;
                        end else begin
                            frame_error <= 1'b1;
                            state_q     <= RESYNC;
                        end
                    end
                    RESYNC: begin
                        if (rx_byte == NL) begin
                            index_q <= '0;
                            state_q <= COLLECT;
                        end
                    end
                    default: begin
                        index_q <= '0;
                        state_q <= COLLECT;
                    end
                endcase
            end else if (timeout_c) begin
                frame_error <= 1'b1;
                index_q     <= '0;
                timer_q     <= '0;
                state_q     <= COLLECT;
            end else if (timer_run_c) begin
                timer_q <= timer_next_c;
            end
        end
    end

    // Saturating error counter, stepped by the same events that pulse frame_error.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            error_count <= '0;
        end else if ((bad_nl_c || timeout_c) && (error_count != 16'hFFFF)) begin
            error_count <= error_count + 16'd1;
        end
    end

endmodule
